// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the SRAM slave: transfer/size encodings,
// response codes and the slave's FSM state encoding.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // ST_DROP completes an error-class transfer as OKAY when error
  // responses are compiled out.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_WR      = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_ERR1    = 3'd5,
    ST_ERR2    = 3'd6,
    ST_DROP    = 3'd7
  } sram_state_t;

  // SEQ is handled exactly like NONSEQ: both request a transfer.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_lane_dec.sv
// Byte-lane decoder: turns the low address bits and HSIZE into active-low
// byte enables, and flags misaligned or over-wide accesses.
module ahb_lane_dec
  import ahb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] addr_lo,
  input  logic [2:0]                  size,
  output logic [DATA_W/8-1:0]         ben_n,
  output logic                        misalign,
  output logic                        oversize
);

  localparam int LANES = DATA_W / 8;
  localparam int LB    = $clog2(LANES);

  // A lane is covered when its index matches the address above the size bits.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [LB-1:0] IDX = LB'(gi);
      assign ben_n[gi] = ((IDX >> size) != (addr_lo >> size));
    end
  endgenerate

  // Any set address bit below the transfer size is a misalignment.
  always_comb begin
    oversize = (int'(size) > LB);
    misalign = 1'b0;
    for (int i = 0; i < LB; i++) begin
      if ((i < int'(size)) && addr_lo[i]) misalign = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a synchronous single-port SRAM with
// LATENCY programmable wait states. Define AHB_SRAM_ERR_EN to get
// two-cycle ERROR responses for out-of-range/misaligned/over-wide
// transfers; otherwise those transfers complete OKAY, writes are
// dropped and reads return zero.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 2**22,
  parameter int LATENCY   = 2
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSEL,
  input  logic [31:0]         HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic                HREADY,
  input  logic [DATA_W-1:0]   HWDATA,
  output logic [DATA_W-1:0]   HRDATA,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic                sram_cen,
  output logic                sram_wen,
  output logic [DATA_W/8-1:0] sram_ben,
  output logic [31:0]         sram_addr,
  output logic [DATA_W-1:0]   sram_din,
  input  logic [DATA_W-1:0]   sram_dout
);

  localparam int LANES = DATA_W / 8;
  localparam int LB    = $clog2(LANES);
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  sram_state_t          state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [31:0]          addr_q, addr_d;
  logic                 write_q, write_d;
  logic [LANES-1:0]     ben_q, ben_d;
  logic [DATA_W-1:0]    hrdata_q, hrdata_d;

  logic [LANES-1:0]     lane_ben;
  logic                 misalign;
  logic                 oversize;
  logic                 xfer_err;
  logic                 ready_state;
  logic                 accept;

  ahb_lane_dec #(.DATA_W(DATA_W)) u_lane_dec (
    .addr_lo  (HADDR[LB-1:0]),
    .size     (HSIZE),
    .ben_n    (lane_ben),
    .misalign (misalign),
    .oversize (oversize)
  );

  // Address-phase qualification and error classification.
  always_comb begin
    ready_state = (state_q == ST_IDLE) || (state_q == ST_WR) ||
                  (state_q == ST_RD_DATA) || (state_q == ST_ERR2) ||
                  (state_q == ST_DROP);
    accept   = ready_state && HSEL && HREADY && htrans_active(HTRANS);
    xfer_err = ({1'b0, HADDR} >= MEM_LIMIT) || misalign || oversize;
  end

  // Next-state logic: walk the data phase, then take a new address phase.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    ben_d    = ben_q;
    hrdata_d = hrdata_q;

    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 3'd0) state_d = write_q ? ST_WR : ST_RD_REQ;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_RD_REQ:  state_d = ST_RD_DATA;
      ST_ERR1:    state_d = ST_ERR2;
      default:    state_d = ST_IDLE;
    endcase

    if (state_q == ST_RD_DATA) hrdata_d = sram_dout;
    if ((state_q == ST_DROP) && !write_q) hrdata_d = '0;

    if (accept) begin
      addr_d  = {HADDR[31:LB], {LB{1'b0}}};
      write_d = HWRITE;
      ben_d   = lane_ben;
      if (xfer_err) begin
`ifdef AHB_SRAM_ERR_EN
        state_d = ST_ERR1;
`else
        state_d = ST_DROP;
`endif
      end else if (LATENCY > 0) begin
        state_d = ST_WAIT;
        cnt_d   = 3'(LATENCY - 1);
      end else begin
        state_d = HWRITE ? ST_WR : ST_RD_REQ;
      end
    end
  end

  // State registers; reset drops any transfer in flight.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      ben_q    <= '1;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      ben_q    <= ben_d;
      hrdata_q <= hrdata_d;
    end
  end

  // Bus and SRAM outputs decoded from the current state.
  always_comb begin
    HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_RD_REQ) ||
                  (state_q == ST_ERR1));
`ifdef AHB_SRAM_ERR_EN
    HRESP = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
    HRESP = HRESP_OKAY;
`endif
    sram_cen  = !((state_q == ST_WR) || (state_q == ST_RD_REQ));
    sram_wen  = !(state_q == ST_WR);
    sram_ben  = sram_cen ? '1 : ben_q;
    sram_addr = addr_q;
    sram_din  = (state_q == ST_WR) ? HWDATA : '0;
    if (state_q == ST_RD_DATA)                    HRDATA = sram_dout;
    else if ((state_q == ST_DROP) && !write_q)    HRDATA = '0;
    else                                          HRDATA = hrdata_q;
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: a LATENCY=2 instance for the main
// transfers, error cases and reset abort, and a LATENCY=0 instance for
// back-to-back traffic. Honours AHB_SRAM_ERR_EN if defined.
module tb_ahb_sram_slave;

  logic        clk;
  logic        rst_n;

  // LATENCY=2 instance bus
  logic        hsel, hwrite;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hready, hreadyout, hresp;
  logic        cen, wen;
  logic [3:0]  ben;
  logic [31:0] saddr, sdin, sdout;

  // LATENCY=0 instance bus
  logic        b_sel, b_write;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [1:0]  b_trans;
  logic [2:0]  b_size;
  logic        b_ready, b_readyout, b_resp;
  logic        b_cen, b_wen;
  logic [3:0]  b_ben;
  logic [31:0] b_saddr, b_sdin, b_sdout;

  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];

  int n_checks = 0;
  int n_pass   = 0;
  int en_cnt   = 0;
  int wr_cnt   = 0;
  logic [3:0] last_ben = 4'hF;

  assign hready  = hreadyout;
  assign b_ready = b_readyout;

  ahb_sram_slave #(.DATA_W(32), .MEM_BYTES(4096), .LATENCY(2)) dut (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready), .HWDATA(hwdata),
    .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp),
    .sram_cen(cen), .sram_wen(wen), .sram_ben(ben), .sram_addr(saddr),
    .sram_din(sdin), .sram_dout(sdout)
  );

  ahb_sram_slave #(.DATA_W(32), .MEM_BYTES(4096), .LATENCY(0)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(b_sel), .HADDR(b_addr), .HTRANS(b_trans),
    .HWRITE(b_write), .HSIZE(b_size), .HREADY(b_ready), .HWDATA(b_wdata),
    .HRDATA(b_rdata), .HREADYOUT(b_readyout), .HRESP(b_resp),
    .sram_cen(b_cen), .sram_wen(b_wen), .sram_ben(b_ben), .sram_addr(b_saddr),
    .sram_din(b_sdin), .sram_dout(b_sdout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    sdout   = '0;
    b_sdout = '0;
  end

  // SRAM models: byte-masked write, read data one cycle after enable.
  always @(posedge clk) begin
    if (!cen) begin
      if (!wen) begin
        for (int i = 0; i < 4; i++)
          if (!ben[i]) mem_a[saddr[11:2]][8*i +: 8] <= sdin[8*i +: 8];
      end else begin
        sdout <= mem_a[saddr[11:2]];
      end
    end
    if (!b_cen) begin
      if (!b_wen) begin
        for (int i = 0; i < 4; i++)
          if (!b_ben[i]) mem_b[b_saddr[11:2]][8*i +: 8] <= b_sdin[8*i +: 8];
      end else begin
        b_sdout <= mem_b[b_saddr[11:2]];
      end
    end
  end

  // Count SRAM enables of the LATENCY=2 instance mid-cycle.
  always @(negedge clk) begin
    if (!cen) en_cnt++;
    if (!cen && !wen) begin
      wr_cnt++;
      last_ben = ben;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // One transfer on the LATENCY=2 instance; call just after a rising edge.
  task automatic bus_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output int cycles, output int resp_cycles,
                          output int ens, output int wrs);
    int en0, wr0, guard;
    en0 = en_cnt;
    wr0 = wr_cnt;
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
    cycles = 0; resp_cycles = 0; guard = 0; rdata = '0;
    forever begin
      @(negedge clk);
      cycles++;
      if (hresp) resp_cycles++;
      if (hreadyout) begin
        rdata = hrdata;
        break;
      end
      if (++guard > 20) begin
        cycles = -1;
        break;
      end
    end
    @(posedge clk); #1;
    ens = en_cnt - en0;
    wrs = wr_cnt - wr0;
    $display("xfer %s addr=%08h size=%0d wdata=%08h rdata=%08h cycles=%0d resp=%0d en=%0d",
             wr ? "WR" : "RD", addr, size, wdata, rdata, cycles, resp_cycles, ens);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_hreadyout"}, 64'(hreadyout), 64'd1);
    check({pfx, "_hresp"},     64'(hresp),     64'd0);
    check({pfx, "_hrdata"},    64'(hrdata),    64'd0);
    check({pfx, "_cen"},       64'(cen),       64'd1);
    check({pfx, "_wen"},       64'(wen),       64'd1);
    check({pfx, "_ben"},       64'(ben),       64'hF);
    check({pfx, "_saddr"},     64'(saddr),     64'd0);
    check({pfx, "_sdin"},      64'(sdin),      64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int cyc, rc, ens, wrs, w0;
    logic [31:0] err_addr [3];
    logic [2:0]  err_size [3];
    err_addr = '{32'h101, 32'd4096, 32'h100};
    err_size = '{3'd1, 3'd2, 3'd3};

    rst_n = 1'b0;
    hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = 3'd2; hwdata = '0;
    b_sel = 1'b0; b_trans = 2'b00; b_addr = '0; b_write = 1'b0; b_size = 3'd2; b_wdata = '0;
    repeat (2) @(posedge clk); #1;
    check_reset_outputs("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Word write then read back
    bus_xfer(1'b1, 32'h100, 3'd2, 32'hDEADBEEF, rd, cyc, rc, ens, wrs);
    check("wr_cycles", 64'(cyc), 64'd3);
    check("wr_pulses", 64'(wrs), 64'd1);
    check("wr_en",     64'(ens), 64'd1);
    check("wr_ben",    64'(last_ben), 64'h0);
    check("wr_resp",   64'(rc),  64'd0);
    bus_xfer(1'b0, 32'h100, 3'd2, 32'h0, rd, cyc, rc, ens, wrs);
    check("rd_cycles", 64'(cyc), 64'd4);
    check("rd_data",   64'(rd),  64'hDEADBEEF);
    check("rd_en",     64'(ens), 64'd1);

    // Byte write into lane 2, then word read
    bus_xfer(1'b1, 32'h102, 3'd0, 32'h00AB0000, rd, cyc, rc, ens, wrs);
    check("bw_cycles", 64'(cyc), 64'd3);
    check("bw_ben",    64'(last_ben), 64'b1011);
    bus_xfer(1'b0, 32'h100, 3'd2, 32'h0, rd, cyc, rc, ens, wrs);
    check("bw_rd_data", 64'(rd), 64'hDEABBEEF);

    // Error-class reads: misaligned half, out of range, over-wide
    for (int k = 0; k < 3; k++) begin
      bus_xfer(1'b0, err_addr[k], err_size[k], 32'h0, rd, cyc, rc, ens, wrs);
      check("err_en", 64'(ens), 64'd0);
`ifdef AHB_SRAM_ERR_EN
      check("err_cycles", 64'(cyc), 64'd2);
      check("err_resp",   64'(rc),  64'd2);
`else
      check("err_cycles", 64'(cyc), 64'd1);
      check("err_resp",   64'(rc),  64'd0);
      check("err_rdata",  64'(rd),  64'd0);
`endif
    end

    // Error-class write is never committed
    bus_xfer(1'b1, 32'h101, 3'd1, 32'hFFFFFFFF, rd, cyc, rc, ens, wrs);
    check("errwr_en", 64'(ens), 64'd0);
    bus_xfer(1'b0, 32'h100, 3'd2, 32'h0, rd, cyc, rc, ens, wrs);
    check("errwr_rd_data", 64'(rd), 64'hDEABBEEF);

    // Reset asserted during the WAIT state of a write
    w0 = wr_cnt;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h200; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h12345678;
    @(negedge clk);
    check("abort_wait_ready", 64'(hreadyout), 64'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    check("abort_no_write", 64'(wr_cnt - w0), 64'd0);
    rst_n = 1'b1;
    $display("xfer WR addr=00000200 aborted by reset");
    @(posedge clk); #1;
    bus_xfer(1'b0, 32'h200, 3'd2, 32'h0, rd, cyc, rc, ens, wrs);
    check("abort_rd_cycles", 64'(cyc), 64'd4);
    check("abort_rd_data",   64'(rd),  64'd0);

    // LATENCY=0: write then read of 0x0 with no idle cycle between
    b_sel = 1'b1; b_trans = 2'b10; b_addr = 32'h0; b_write = 1'b1; b_size = 3'd2;
    @(posedge clk); #1;
    b_wdata = 32'h5A5A1234; b_write = 1'b0;
    @(negedge clk);
    check("b2b_wr_ready", 64'(b_readyout), 64'd1);
    check("b2b_wr_strobe", 64'({b_cen, b_wen}), 64'b00);
    check("b2b_wr_din", 64'(b_sdin), 64'h5A5A1234);
    $display("xfer WR addr=00000000 wdata=5a5a1234 (latency 0)");
    @(posedge clk); #1;
    b_sel = 1'b0; b_trans = 2'b00;
    @(negedge clk);
    check("b2b_rd_req_ready", 64'(b_readyout), 64'd0);
    check("b2b_rd_req_cen", 64'(b_cen), 64'd0);
    @(negedge clk);
    check("b2b_rd_ready", 64'(b_readyout), 64'd1);
    check("b2b_rd_data",  64'(b_rdata), 64'h5A5A1234);
    $display("xfer RD addr=00000000 rdata=%08h (latency 0)", b_rdata);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
